// File: rtl/sprite_tick_pkg.sv
// Shared constants and types for the sprite timebase.
package sprite_tick_pkg;

  localparam int unsigned SYS_CLK_HZ = 100_000_000;
  localparam int unsigned DEF_CNT_W  = 22;
  localparam int unsigned DEF_DIV    = 3_000_000;

  typedef logic [DEF_CNT_W-1:0] tick_div_t;

endpackage

// File: rtl/sprite_tick_chan.sv
// One timebase channel: divisor register, counter, tick pulse and optional wave.
// The wave flop exists only when SPRITE_TICK_GEN_WAVE_EN is defined; otherwise wave_o is 0.
module sprite_tick_chan
  import sprite_tick_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             resync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             tick_o,
  output logic             wave_o
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [CNT_W-1:0] lim_s;
  logic             wrap_s;

  // Zero divisor behaves as one; the subtraction happens after the clamp so it never underflows.
  assign lim_s  = ((div_q == '0) ? ONE : div_q) - ONE;
  // Using >= lets a lowered divisor wrap at once instead of running through the full range.
  assign wrap_s = en_i & ~resync_i & (cnt_q >= lim_s);

  // Next-state for divisor, counter and tick; resync wins over counting.
  always_comb begin
    div_d  = div_q;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (wr_i) begin
      div_d = wr_div_i;
    end else begin
      div_d = div_q;
    end
    if (resync_i) begin
      cnt_d = '0;
    end else if (wrap_s) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else if (en_i) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q  <= DIV_RST;
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

`ifdef SPRITE_TICK_GEN_WAVE_EN
  logic wave_q, wave_d;

  // Wave toggles on every wrap, giving a 50 % duty square at half the tick rate.
  always_comb begin
    wave_d = wave_q ^ wrap_s;
  end

  // Wave register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wave_q <= 1'b0;
    end else begin
      wave_q <= wave_d;
    end
  end

  assign wave_o = wave_q;
`else
  assign wave_o = 1'b0;
`endif

endmodule

// File: rtl/sprite_tick_gen.sv
// Multi-channel sprite timebase: NCH independent programmable tick generators.
// Optional feature macro: SPRITE_TICK_GEN_WAVE_EN builds the per-channel wave outputs.
module sprite_tick_gen
  import sprite_tick_pkg::*;
#(
  parameter int unsigned NCH         = 4,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV,
  parameter int unsigned CH_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             CLK_100MHz,
  input  logic             RST,
  input  logic [NCH-1:0]   en,
  input  logic             resync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   wave
);

  logic [NCH-1:0] wr_sel_s;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Channels that do not exist never match, so out-of-range wr_ch is ignored.
    assign wr_sel_s[i] = wr_en & (wr_ch == CH_W'(i));

    sprite_tick_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i    (CLK_100MHz),
      .rst_i    (RST),
      .en_i     (en[i]),
      .resync_i (resync),
      .wr_i     (wr_sel_s[i]),
      .wr_div_i (wr_div),
      .tick_o   (tick[i]),
      .wave_o   (wave[i])
    );
  end

endmodule

// File: tb/tb_sprite_tick_gen.sv
// Scoreboard bench for sprite_tick_gen: a cycle model pushes expected tick/wave per cycle.
module tb_sprite_tick_gen;

  localparam int NCH   = 4;
  localparam int CNT_W = 22;
  localparam int CH_W  = 2;
  localparam int DDIV  = 3000000;

  logic             clk_s = 1'b0;
  logic             rst_s = 1'b1;
  logic [NCH-1:0]   en_s = '0;
  logic             resync_s = 1'b0;
  logic             wr_en_s = 1'b0;
  logic [CH_W-1:0]  wr_ch_s = '0;
  logic [CNT_W-1:0] wr_div_s = '0;
  logic [NCH-1:0]   tick_s;
  logic [NCH-1:0]   wave_s;

  int n_checks = 0;
  int n_errors = 0;

  logic [CNT_W-1:0] m_div [NCH];
  logic [CNT_W-1:0] m_cnt [NCH];
  logic [NCH-1:0]   m_tick;
  logic [NCH-1:0]   m_wave;
  logic [2*NCH-1:0] exp_q [$];

  int ticks0;
  int ticks2;

  sprite_tick_gen #(.NCH(NCH), .CNT_W(CNT_W), .DEFAULT_DIV(DDIV)) dut (
    .CLK_100MHz (clk_s),
    .RST        (rst_s),
    .en         (en_s),
    .resync     (resync_s),
    .wr_en      (wr_en_s),
    .wr_ch      (wr_ch_s),
    .wr_div     (wr_div_s),
    .tick       (tick_s),
    .wave       (wave_s)
  );

  always #5 clk_s = ~clk_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i] = CNT_W'(DDIV);
      m_cnt[i] = '0;
    end
    m_tick = '0;
    m_wave = '0;
  endtask

  task automatic model_step(input logic [NCH-1:0] e, input logic rs, input logic we,
                            input logic [CH_W-1:0] wc, input logic [CNT_W-1:0] wd);
    logic [CNT_W-1:0] d;
    for (int i = 0; i < NCH; i++) begin
      d = (m_div[i] == 0) ? CNT_W'(1) : m_div[i];
      if (rs) begin
        m_cnt[i]  = '0;
        m_tick[i] = 1'b0;
      end else if (e[i]) begin
        if (m_cnt[i] >= d - CNT_W'(1)) begin
          m_cnt[i]  = '0;
          m_tick[i] = 1'b1;
          m_wave[i] = ~m_wave[i];
        end else begin
          m_cnt[i]  = m_cnt[i] + CNT_W'(1);
          m_tick[i] = 1'b0;
        end
      end else begin
        m_tick[i] = 1'b0;
      end
      if (we && int'(wc) == i) m_div[i] = wd;
    end
  endtask

  // Drive one cycle of stimulus, push the model's expectation, then compare after the edge.
  task automatic drive(input logic [NCH-1:0] e, input logic rs, input logic we,
                       input logic [CH_W-1:0] wc, input logic [CNT_W-1:0] wd);
    logic [2*NCH-1:0] ex;
    logic [NCH-1:0]   ew;
    en_s = e; resync_s = rs; wr_en_s = we; wr_ch_s = wc; wr_div_s = wd;
    model_step(e, rs, we, wc, wd);
`ifdef SPRITE_TICK_GEN_WAVE_EN
    ew = m_wave;
`else
    ew = '0;
`endif
    exp_q.push_back({m_tick, ew});
    @(posedge clk_s);
    #1;
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      ex = exp_q.pop_front();
      chk("tick", 32'(tick_s), 32'(ex[2*NCH-1:NCH]));
      chk("wave", 32'(wave_s), 32'(ex[NCH-1:0]));
    end
    ticks0 += int'(tick_s[0]);
    ticks2 += int'(tick_s[2]);
    en_s = '0; resync_s = 1'b0; wr_en_s = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk_s);
    #1;
    chk("rst_tick", 32'(tick_s), 32'd0);
    chk("rst_wave", 32'(wave_s), 32'd0);
    rst_s = 1'b0;

    // ch0 at D=5, only ch0 enabled
    ticks0 = 0;
    drive(4'b0001, 1'b0, 1'b1, 2'd0, 22'd5);
    for (int k = 0; k < 49; k++) drive(4'b0001, 1'b0, 1'b0, 2'd0, 22'd0);
    chk("t1_tick_count", 32'(ticks0), 32'd10);

    // ch1 at D=10, count to 7, then lower to 3
    drive(4'b0010, 1'b1, 1'b1, 2'd1, 22'd10);
    for (int k = 0; k < 7; k++) drive(4'b0010, 1'b0, 1'b0, 2'd0, 22'd0);
    drive(4'b0010, 1'b0, 1'b1, 2'd1, 22'd3);
    drive(4'b0010, 1'b0, 1'b0, 2'd0, 22'd0);
    chk("t2_wrap", 32'(tick_s[1]), 32'd1);
    for (int k = 0; k < 9; k++) drive(4'b0010, 1'b0, 1'b0, 2'd0, 22'd0);

    // ch2 at D=0 ticks every enabled cycle
    drive(4'b0100, 1'b0, 1'b1, 2'd2, 22'd0);
    for (int k = 0; k < 6; k++) drive(4'b0100, 1'b0, 1'b0, 2'd0, 22'd0);
    chk("t3_tick_every", 32'(tick_s[2]), 32'd1);

    // ch3 at D=4, pause for 6 cycles after 2 enabled cycles
    drive(4'b1000, 1'b1, 1'b1, 2'd3, 22'd4);
    drive(4'b1000, 1'b0, 1'b0, 2'd0, 22'd0);
    drive(4'b1000, 1'b0, 1'b0, 2'd0, 22'd0);
    for (int k = 0; k < 6; k++) drive(4'b0000, 1'b0, 1'b0, 2'd0, 22'd0);
    drive(4'b1000, 1'b0, 1'b0, 2'd0, 22'd0);
    chk("t4_no_early", 32'(tick_s[3]), 32'd0);
    drive(4'b1000, 1'b0, 1'b0, 2'd0, 22'd0);
    chk("t4_resume", 32'(tick_s[3]), 32'd1);

    // resync together with a ch0 write of D=6
    drive(4'b1111, 1'b1, 1'b1, 2'd0, 22'd6);
    ticks0 = 0;
    for (int k = 0; k < 5; k++) drive(4'b0001, 1'b0, 1'b0, 2'd0, 22'd0);
    chk("t5_no_early", 32'(ticks0), 32'd0);
    drive(4'b0001, 1'b0, 1'b0, 2'd0, 22'd0);
    chk("t5_tick", 32'(tick_s[0]), 32'd1);

    // asynchronous reset while ch2 is ticking every cycle
    drive(4'b0100, 1'b0, 1'b0, 2'd0, 22'd0);
    drive(4'b0100, 1'b0, 1'b0, 2'd0, 22'd0);
    chk("t6_pre_tick2", 32'(tick_s[2]), 32'd1);
    #2;
    rst_s = 1'b1;
    #1;
    chk("t6_async_tick", 32'(tick_s), 32'd0);
    chk("t6_async_wave", 32'(wave_s), 32'd0);
    model_reset();
    @(posedge clk_s);
    #1;
    rst_s = 1'b0;
    ticks0 = 0;
    ticks2 = 0;
    for (int k = 0; k < 20; k++) drive(4'b0101, 1'b0, 1'b0, 2'd0, 22'd0);
    chk("t6_div0_restored", 32'(ticks0), 32'd0);
    chk("t6_div2_restored", 32'(ticks2), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
